// File: rtl/bitwise_logic_pipe_pkg.sv
// Shared op codes, occupancy states and default width for the bitwise logic pipe.
// Optional feature macro: BITWISE_ACC_EN (op 111 becomes ACC instead of PASSA).
package bitwise_logic_pipe_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOR   = 3'b011,
    OP_XNOR  = 3'b100,
    OP_NAND  = 3'b101,
    OP_ANDN  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

  // ACC shares the PASSA code when the accumulator is built in
  localparam op_e OP_ACC = OP_PASSA;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/bitwise_op_core.sv
// Combinational bitwise op core: per-bit primitive gates plus the op select mux.
// Optional feature macro: BITWISE_ACC_EN (op 111 computes acc_clr ? a : acc ^ a).
module bitwise_op_core
  import bitwise_logic_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BITWISE_ACC_EN
  input  logic [WIDTH-1:0] acc,
  input  logic             acc_clr,
`endif
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] and_v, or_v, xor_v, andn_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_v[i]  = a[i] & b[i];
    assign or_v[i]   = a[i] | b[i];
    assign xor_v[i]  = a[i] ^ b[i];
    assign andn_v[i] = a[i] & ~b[i];
  end

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:   y = and_v;
      OP_OR:    y = or_v;
      OP_XOR:   y = xor_v;
      OP_NOR:   y = ~or_v;
      OP_XNOR:  y = ~xor_v;
      OP_NAND:  y = ~and_v;
      OP_ANDN:  y = andn_v;
`ifdef BITWISE_ACC_EN
      OP_ACC:   y = acc_clr ? a : (acc ^ a);
`else
      OP_PASSA: y = a;
`endif
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Registered bitwise logic unit with valid/ready on both sides and a 2-entry
// skid (out reg + skid reg). Optional feature macro: BITWISE_ACC_EN.
module bitwise_logic_pipe
  import bitwise_logic_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BITWISE_ACC_EN
  input  logic             acc_clr,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero
);

  state_e           state, state_nxt;
  logic             accept, rel;
  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic [WIDTH-1:0] skid_y;
  logic             skid_zero;
  logic             load_new, load_skid, skid_we;

`ifdef BITWISE_ACC_EN
  logic [WIDTH-1:0] acc;
`endif

  bitwise_op_core #(.WIDTH(WIDTH)) u_core (
    .op      (op),
    .a       (a),
    .b       (b),
`ifdef BITWISE_ACC_EN
    .acc     (acc),
    .acc_clr (acc_clr),
`endif
    .y       (res)
  );

  assign res_zero  = (res == '0);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state != ST_EMPTY);
  assign rel       = out_valid & out_ready;

  // out reg takes a new result when free or draining; skid drains first when full
  assign load_skid = (state == ST_TWO) & rel;
  assign load_new  = accept & ((state == ST_EMPTY) | rel);
  assign skid_we   = accept & (state == ST_ONE) & ~rel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !rel)      state_nxt = ST_TWO;
        else if (!accept && rel) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (rel) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // in_ready is a flop so it never depends combinationally on out_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_ready <= 1'b1;
    else       in_ready <= (state_nxt != ST_TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y         <= '0;
      y_zero    <= 1'b1;
      skid_y    <= '0;
      skid_zero <= 1'b1;
    end else begin
      if (load_skid) begin
        y      <= skid_y;
        y_zero <= skid_zero;
      end else if (load_new) begin
        y      <= res;
        y_zero <= res_zero;
      end
      if (skid_we) begin
        skid_y    <= res;
        skid_zero <= res_zero;
      end
    end
  end

`ifdef BITWISE_ACC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              acc <= '0;
    else if (accept && op_e'(op) == OP_ACC) acc <= res;
  end
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe; define BITWISE_ACC_EN to also
// cover the accumulator op.
module tb_bitwise_logic_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
`ifdef BITWISE_ACC_EN
  logic         acc_clr;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         y_zero;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  bitwise_logic_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
`ifdef BITWISE_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_zero    (y_zero)
  );

  // Reference: op semantics straight from the op table; op 7 updates the acc model.
  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    logic [W-1:0] r;
    case (o)
      3'd0: r = x & z;
      3'd1: r = x | z;
      3'd2: r = x ^ z;
      3'd3: r = ~(x | z);
      3'd4: r = ~(x ^ z);
      3'd5: r = ~(x & z);
      3'd6: r = x & ~z;
      default: begin
`ifdef BITWISE_ACC_EN
        m_acc = acc_clr ? x : (m_acc ^ x);
        r = m_acc;
`else
        r = x;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
`ifdef BITWISE_ACC_EN
    acc_clr = 1'b0;
`endif
    m_acc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    next_cycle();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (y !== '0) begin n_err++; $display("FAIL reset_y got %h want 0", y); end
    n_cmp++; if (y_zero !== 1'b1) begin n_err++; $display("FAIL reset_y_zero got %b want 1", y_zero); end
  endtask

  task automatic test_ops();
    logic [W-1:0] tbl [8];
    tbl[0] = 32'h00F0_1234; tbl[1] = 32'hFFF0_FFFF; tbl[2] = 32'hFF00_EDCB; tbl[3] = 32'h000F_0000;
    tbl[4] = 32'h00FF_1234; tbl[5] = 32'hFF0F_EDCB; tbl[6] = 32'hF000_0000; tbl[7] = 32'hF0F0_1234;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = i[2:0]; a = 32'hF0F0_1234; b = 32'h0FF0_FFFF; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ops_in_ready op=%0d got %b want 1", i, in_ready); end
      next_cycle();
      in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ops_latency op=%0d out_valid got %b want 1", i, out_valid); end
      n_cmp++; if (y !== tbl[i]) begin n_err++; $display("FAIL ops_y op=%0d got %h want %h", i, y, tbl[i]); end
      n_cmp++; if (y_zero !== 1'b0) begin n_err++; $display("FAIL ops_y_zero op=%0d got %b want 0", i, y_zero); end
      next_cycle();
    end
    // op 7 with acc=0 and acc_clr=0 in the ACC build leaves acc = a
`ifdef BITWISE_ACC_EN
    m_acc = 32'hF0F0_1234;
`endif
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ops_drained out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_zero();
    in_valid = 1'b1; op = 3'd2; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (y !== '0) begin n_err++; $display("FAIL zero_y got %h want 0", y); end
    n_cmp++; if (y_zero !== 1'b1) begin n_err++; $display("FAIL zero_flag got %b want 1", y_zero); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r [3];
    logic [2:0]   ops [3];
    logic [W-1:0] as [3], bs [3];
    for (int i = 0; i < 3; i++) begin
      ops[i] = 3'($urandom_range(0, 6)); as[i] = $urandom; bs[i] = $urandom;
      r[i] = ref_op(ops[i], as[i], bs[i]);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; op = ops[0]; a = as[0]; b = bs[0];
    next_cycle();
    op = ops[1]; a = as[1]; b = bs[1];
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after1 got %b want 1", in_ready); end
    n_cmp++; if (y !== r[0]) begin n_err++; $display("FAIL b2b_first_y got %h want %h", y, r[0]); end
    next_cycle();
    op = ops[2]; a = as[2]; b = bs[2];
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after2 got %b want 0", in_ready); end
    next_cycle();
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_held got %b want 0", in_ready); end
    n_cmp++; if (y !== r[0] || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_stall_stable got %h/%b want %h/1", y, out_valid, r[0]); end
    out_ready = 1'b1;
    next_cycle();
    #1;
    n_cmp++; if (y !== r[1] || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_drain2 got %h/%b want %h/1", y, out_valid, r[1]); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_reopen got %b want 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (y !== r[2] || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_third got %h/%b want %h/1", y, out_valid, r[2]); end
    next_cycle();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    int sent = 0, got = 0, cyc = 0;
    logic hold = 1'b0;
    logic [W-1:0] hold_y = '0;
    exp_q.delete();
    while (got < 100 && cyc < 3000) begin
      in_valid  = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
`ifdef BITWISE_ACC_EN
      acc_clr = 1'($urandom_range(0, 1));
`endif
      #1;
      if (hold) begin
        n_cmp++; if (out_valid !== 1'b1 || y !== hold_y) begin n_err++; $display("FAIL rand_stall_hold got %h/%b want %h/1", y, out_valid, hold_y); end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_extra got %h want nothing", y); end
        else begin
          if (y !== exp_q[0] || y_zero !== (exp_q[0] == '0)) begin
            n_err++; $display("FAIL rand_result #%0d got %h/%b want %h/%b", got, y, y_zero, exp_q[0], (exp_q[0] == '0));
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_op(op, a, b));
        sent++;
      end
      hold = out_valid & ~out_ready;
      hold_y = y;
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 100 || exp_q.size() != 0) begin n_err++; $display("FAIL rand_count got %0d outstanding %0d want 100/0", got, exp_q.size()); end
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_final_empty got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'($urandom_range(0, 6)); a = $urandom; b = $urandom;
    next_cycle();
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_full got %b want 0", in_ready); end
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_async got %b/%b want 0/1", out_valid, in_ready); end
    next_cycle();
    reset = 1'b0;
    m_acc = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== '0) begin n_err++; $display("FAIL rstmid_stale cyc=%0d got %b/%b/%h want 0/1/0", i, out_valid, in_ready, y); end
      next_cycle();
    end
  endtask

`ifdef BITWISE_ACC_EN
  task automatic test_acc();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd7; acc_clr = 1'b1; a = 32'h0000_00FF; b = $urandom;
    next_cycle();
    acc_clr = 1'b0; a = 32'h0000_0F0F;
    #1;
    n_cmp++; if (y !== 32'h0000_00FF) begin n_err++; $display("FAIL acc_clr_load got %h want 000000ff", y); end
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (y !== 32'h0000_0FF0) begin n_err++; $display("FAIL acc_xor got %h want 00000ff0", y); end
    next_cycle();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
    next_cycle();
    next_cycle();
    op = 3'd7; acc_clr = 1'b0; a = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL acc_stall_ready cyc=%0d got %b want 0", i, in_ready); end
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    next_cycle();
    next_cycle();
    in_valid = 1'b1; op = 3'd7; acc_clr = 1'b0; a = '0;
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (y !== 32'h0000_0FF0) begin n_err++; $display("FAIL acc_unchanged got %h want 00000ff0", y); end
    next_cycle();
  endtask
`endif

  initial begin
    fork
      begin
        test_reset();
        test_ops();
        test_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef BITWISE_ACC_EN
        test_acc();
`endif
      end
      begin
        #200000;
        $display("FAIL timeout compared %0d", n_cmp);
        $fatal(1, "bench timeout");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
